// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the stage-count derivation.
package shifter_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // ceil(log2(width)); also the pipeline depth
  function automatic int sh_w(input int width);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < width) n = i + 1;
    return n;
  endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operand/result handshake bundle for shifter_pipe.
interface shifter_pipe_if
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  localparam int SH_W = sh_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SH_W-1:0]  in_shamt;
  mode_e            in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shifter_pipe_shift_stage.sv
// One combinational barrel-shifter level: shift/rotate by 2^K when en_i is set.
module shift_stage
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;

  // SRA fills from the current MSB, which right shifts never alter,
  // so it is always the operand's original sign bit.
  always_comb begin
    case (mode_i)
      MODE_SLL: shifted = {data_i[WIDTH-1-S:0], {S{1'b0}}};
      MODE_SRL: shifted = {{S{1'b0}}, data_i[WIDTH-1:S]};
      MODE_SRA: shifted = {{S{data_i[WIDTH-1]}}, data_i[WIDTH-1:S]};
      default:  shifted = {data_i[WIDTH-1-S:0], data_i[WIDTH-1:WIDTH-S]};
    endcase
    data_o = en_i ? shifted : data_i;
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined shifter: SH_W registered stages, stage k shifts by 2^k.
// The whole pipe advances or stalls as one unit on output backpressure.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  shifter_pipe_if.slave bus
);
  localparam int SH_W = sh_w(WIDTH);

  logic                             advance;
  logic                             accept;
  logic [SH_W-1:0]                  vld_q;
  logic [SH_W-1:0][WIDTH-1:0]       data_q, data_d, stg_in;
  logic [SH_W-1:0][SH_W-1:0]        shamt_q;
  logic [SH_W-1:0][1:0]             mode_q, stg_mode;
  logic [SH_W-1:0][TAG_W-1:0]       tag_q;
  logic [SH_W-1:0]                  stg_en;

  assign advance      = !vld_q[SH_W-1] || bus.out_ready;
  assign accept       = bus.in_valid && advance;
  assign bus.in_ready = advance;

  assign bus.out_valid = vld_q[SH_W-1];
  assign bus.out_data  = data_q[SH_W-1];
  assign bus.out_tag   = tag_q[SH_W-1];

  assign stg_in[0]   = bus.in_data;
  assign stg_en[0]   = bus.in_shamt[0];
  assign stg_mode[0] = bus.in_mode;

  for (genvar k = 1; k < SH_W; k++) begin : g_link
    assign stg_in[k]   = data_q[k-1];
    assign stg_en[k]   = shamt_q[k-1][k];
    assign stg_mode[k] = mode_q[k-1];
  end

  for (genvar k = 0; k < SH_W; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .data_i (stg_in[k]),
      .en_i   (stg_en[k]),
      .mode_i (mode_e'(stg_mode[k])),
      .data_o (data_d[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q   <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
    end else if (advance) begin
      vld_q   <= {vld_q[SH_W-2:0], accept};
      data_q  <= data_d;
      shamt_q <= {shamt_q[SH_W-2:0], bus.in_shamt};
      mode_q  <= {mode_q[SH_W-2:0], bus.in_mode};
      tag_q   <= {tag_q[SH_W-2:0], bus.in_tag};
    end
  end

  // Already-consumed shamt bits and the last stage's mode ride along unused.
  logic unused_bits;
  assign unused_bits = ^{shamt_q, mode_q[SH_W-1]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=32, TAG_W=5) with directed vectors.
module tb_shifter_pipe;
  import shifter_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int SH_W  = 5;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  shifter_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0d data %h, expected no result",
                 bus.out_tag, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_tag", 32'(bus.out_tag), 32'(e.tag));
        if (e.due >= 0) check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Offer one op, wait for acceptance, then scramble the inputs.
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input mode_e m,
                      input logic [4:0] t, input logic [31:0] expv,
                      input bit timed, input bit track);
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_mode  = m;
    bus.in_tag   = t;
    @(negedge clock);
    while (!bus.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, expected 1", n);
    end else if (track) begin
      e.data = expv;
      e.tag  = t;
      e.due  = timed ? cyc + SH_W : -1;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mode  = mode_e'(~m);
    bus.in_shamt = ~sh;
    bus.in_data  = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    logic [31:0] stream_exp [8];
    stream_exp = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80};

    bus.in_data   = 32'h1234_5678;
    bus.in_shamt  = 5'd3;
    bus.in_mode   = MODE_SLL;
    bus.in_tag    = 5'd31;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;  // must not be accepted while reset is high
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;

    @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_tag", 32'(bus.out_tag), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clock);
    #1;

    // Isolated op: latency check
    send(32'h0000FFFF, 5'd16, MODE_SLL, 5'd3, 32'hFFFF0000, 1, 1);
    drain();

    // Directed vectors, back to back
    send(32'h80000000, 5'd31, MODE_SRA, 5'd4,  32'hFFFFFFFF, 1, 1);
    send(32'h80000000, 5'd31, MODE_SRL, 5'd5,  32'h00000001, 1, 1);
    send(32'h80000001, 5'd1,  MODE_ROL, 5'd6,  32'h00000003, 1, 1);
    send(32'hDEADBEEF, 5'd0,  MODE_SLL, 5'd8,  32'hDEADBEEF, 1, 1);
    send(32'hDEADBEEF, 5'd0,  MODE_SRL, 5'd9,  32'hDEADBEEF, 1, 1);
    send(32'hDEADBEEF, 5'd0,  MODE_SRA, 5'd10, 32'hDEADBEEF, 1, 1);
    send(32'hDEADBEEF, 5'd0,  MODE_ROL, 5'd11, 32'hDEADBEEF, 1, 1);
    send(32'h00000001, 5'd31, MODE_SLL, 5'd12, 32'h80000000, 1, 1);
    send(32'hF0000000, 5'd4,  MODE_SRL, 5'd13, 32'h0F000000, 1, 1);
    send(32'hF0000000, 5'd4,  MODE_SRA, 5'd14, 32'hFF000000, 1, 1);
    send(32'h40000000, 5'd30, MODE_SRA, 5'd15, 32'h00000001, 1, 1);
    send(32'h12345678, 5'd8,  MODE_ROL, 5'd16, 32'h34567812, 1, 1);
    send(32'h80000000, 5'd31, MODE_ROL, 5'd17, 32'h40000000, 1, 1);
    drain();

    // Streaming: 8 ops, results on consecutive cycles from cycle 5
    for (int i = 0; i < 8; i++)
      send(32'h1, 5'(i), MODE_SLL, 5'(i), stream_exp[i], 1, 1);
    drain();

    // Backpressure: fill the pipe with out_ready low
    bus.out_ready = 1'b0;
    send(32'h00000001, 5'd4, MODE_SLL, 5'd20, 32'h00000010, 0, 1);
    send(32'h00000100, 5'd8, MODE_SRL, 5'd21, 32'h00000001, 0, 1);
    send(32'h80000000, 5'd4, MODE_SRA, 5'd22, 32'hF8000000, 0, 1);
    send(32'hF0000000, 5'd4, MODE_ROL, 5'd23, 32'h0000000F, 0, 1);
    send(32'hA5A5A5A5, 5'd0, MODE_SLL, 5'd24, 32'hA5A5A5A5, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      check("bp_data_hold", bus.out_data, 32'h00000010);
      check("bp_tag_hold", 32'(bus.out_tag), 32'd20);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Reset with 3 ops in flight: all discarded
    send(32'h11111111, 5'd1, MODE_SLL, 5'd1, 32'h0, 0, 0);
    send(32'h22222222, 5'd2, MODE_SRL, 5'd2, 32'h0, 0, 0);
    send(32'h33333333, 5'd3, MODE_ROL, 5'd3, 32'h0, 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_out_data", bus.out_data, 32'h0);
    check("midrst_out_tag", 32'(bus.out_tag), 32'h0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid) vcnt++;
    end
    check("midrst_stale_results", 32'(vcnt), 32'h0);
    @(posedge clock);
    #1;
    send(32'h0000ABCD, 5'd16, MODE_SLL, 5'd7, 32'hABCD0000, 1, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
